// File: rtl/sincronizador_pkg.sv
// sincronizador_pkg: edge-mode encoding and default sizing shared by the input conditioner.
package sincronizador_pkg;
   typedef enum logic [1:0] {
      MODO_OFF    = 2'b00,
      MODO_SUBIDA = 2'b01,
      MODO_BAJADA = 2'b10,
      MODO_AMBOS  = 2'b11
   } modo_t;
   localparam int N_CANALES_DEF       = 4;
   localparam int ETAPAS_SYNC_DEF     = 2;
   localparam int CICLOS_DEBOUNCE_DEF = 4;
endpackage

// File: rtl/sincronizador_multicanal_if.sv
// sincronizador_multicanal_if: raw inputs/modes in, debounced levels/pulses out.
// SINC_STICKY_EN adds limpiar/evento sticky-event signals.
interface sincronizador_multicanal_if
   import sincronizador_pkg::*;
#(
   parameter int N_CANALES = N_CANALES_DEF
);
   logic [N_CANALES-1:0]   inp;
   logic [2*N_CANALES-1:0] modo;
   logic [N_CANALES-1:0]   nivel;
   logic [N_CANALES-1:0]   pulso;
`ifdef SINC_STICKY_EN
   logic [N_CANALES-1:0]   limpiar;
   logic [N_CANALES-1:0]   evento;
   modport master (output inp, modo, limpiar, input nivel, pulso, evento);
   modport slave  (input inp, modo, limpiar, output nivel, pulso, evento);
`else
   modport master (output inp, modo, input nivel, pulso);
   modport slave  (input inp, modo, output nivel, pulso);
`endif
endinterface

// File: rtl/sincronizador_canal.sv
// sincronizador_canal: one channel of synchroniser, debounce filter and edge pulse.
// SINC_STICKY_EN adds a sticky event bit set by the pulse and cleared by i_limpiar.
module sincronizador_canal
   import sincronizador_pkg::*;
#(
   parameter int ETAPAS_SYNC     = ETAPAS_SYNC_DEF,
   parameter int CICLOS_DEBOUNCE = CICLOS_DEBOUNCE_DEF
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  i_inp,
   input  modo_t i_modo,
`ifdef SINC_STICKY_EN
   input  logic  i_limpiar,
   output logic  o_evento,
`endif
   output logic  o_nivel,
   output logic  o_pulso
);
   localparam int CW = $clog2(CICLOS_DEBOUNCE + 1);
   logic [ETAPAS_SYNC-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_nivel, r_pulso;
   logic                   w_sync, w_cambio, w_permite;
   assign w_sync    = r_sync[ETAPAS_SYNC-1];
   assign w_cambio  = (w_sync != r_nivel) && (r_cnt == CW'(CICLOS_DEBOUNCE - 1));
   // modo is only consulted on the accepting edge, so late changes never act retroactively
   assign w_permite = (i_modo == MODO_AMBOS) || (i_modo == (w_sync ? MODO_SUBIDA : MODO_BAJADA));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_nivel <= 1'b0;
         r_pulso <= 1'b0;
      end else begin
         r_sync  <= {r_sync[ETAPAS_SYNC-2:0], i_inp};
         r_cnt   <= (w_sync == r_nivel || w_cambio) ? '0 : r_cnt + CW'(1);
         r_nivel <= w_cambio ? w_sync : r_nivel;
         r_pulso <= w_cambio && w_permite;
      end
   end
`ifdef SINC_STICKY_EN
   logic r_evento;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_evento <= 1'b0;
      else     r_evento <= (w_cambio && w_permite) || (r_evento && !i_limpiar);
   end
   assign o_evento = r_evento;
`endif
   assign o_nivel = r_nivel;
   assign o_pulso = r_pulso;
endmodule

// File: rtl/sincronizador_multicanal.sv
// sincronizador_multicanal: N independent conditioned input channels.
// SINC_STICKY_EN enables per-channel sticky event flags.
module sincronizador_multicanal
   import sincronizador_pkg::*;
#(
   parameter int N_CANALES       = N_CANALES_DEF,
   parameter int ETAPAS_SYNC     = ETAPAS_SYNC_DEF,
   parameter int CICLOS_DEBOUNCE = CICLOS_DEBOUNCE_DEF
) (
   input logic                       clk,
   input logic                       rst,
   sincronizador_multicanal_if.slave bus
);
   logic [N_CANALES-1:0] w_nivel, w_pulso;
`ifdef SINC_STICKY_EN
   logic [N_CANALES-1:0] w_evento;
   assign bus.evento = w_evento;
`endif
   for (genvar g = 0; g < N_CANALES; g++) begin : g_canal
      sincronizador_canal #(
         .ETAPAS_SYNC    (ETAPAS_SYNC),
         .CICLOS_DEBOUNCE(CICLOS_DEBOUNCE)
      ) u_canal (
         .clk      (clk),
         .rst      (rst),
         .i_inp    (bus.inp[g]),
         .i_modo   (modo_t'(bus.modo[2*g+:2])),
`ifdef SINC_STICKY_EN
         .i_limpiar(bus.limpiar[g]),
         .o_evento (w_evento[g]),
`endif
         .o_nivel  (w_nivel[g]),
         .o_pulso  (w_pulso[g])
      );
   end
   assign bus.nivel = w_nivel;
   assign bus.pulso = w_pulso;
endmodule

// File: tb/tb_sincronizador_multicanal.sv
// tb_sincronizador_multicanal: directed checks of latency, glitch rejection, edge modes and reset.
module tb_sincronizador_multicanal;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   sincronizador_multicanal_if #(.N_CANALES(4)) bus_if ();
   sincronizador_multicanal #(.N_CANALES(4), .ETAPAS_SYNC(2), .CICLOS_DEBOUNCE(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if.slave)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic settle_low();
      bus_if.inp = 4'b0000;
      repeat (10) tick();
   endtask
   task automatic test_reset();
      bus_if.inp  = 4'b0000;
      bus_if.modo = 8'h55;
`ifdef SINC_STICKY_EN
      bus_if.limpiar = 4'b0000;
`endif
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if (bus_if.nivel !== 4'b0000 || bus_if.pulso !== 4'b0000) begin
         failures++;
         $display("FAIL reset: nivel=%b pulso=%b expected 0000/0000", bus_if.nivel, bus_if.pulso);
      end
      rst = 1'b0;
      tick();
   endtask
   task automatic test_subida();
      bus_if.inp = 4'b0001;
      repeat (5) tick();
      checks++;
      if (bus_if.nivel !== 4'b0000) begin
         failures++;
         $display("FAIL subida_early: nivel=%b expected 0000", bus_if.nivel);
      end
      tick();
      checks++;
      if (bus_if.nivel !== 4'b0001 || bus_if.pulso !== 4'b0001) begin
         failures++;
         $display("FAIL subida_edge: nivel=%b pulso=%b expected 0001/0001", bus_if.nivel, bus_if.pulso);
      end
      tick();
      checks++;
      if (bus_if.nivel !== 4'b0001 || bus_if.pulso !== 4'b0000) begin
         failures++;
         $display("FAIL subida_after: nivel=%b pulso=%b expected 0001/0000", bus_if.nivel, bus_if.pulso);
      end
   endtask
   task automatic test_glitch();
      logic seen;
      seen = 1'b0;
      bus_if.inp[1] = 1'b1;
      repeat (2) tick();
      bus_if.inp[1] = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         seen = seen | bus_if.nivel[1] | bus_if.pulso[1];
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL glitch: channel1 activity=%b expected 0", seen);
      end
   endtask
   task automatic run_canal2(input logic val, input int exp_cnt, input string nombre);
      int cnt;
      int pos;
      cnt = 0;
      pos = -1;
      bus_if.inp[2] = val;
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (bus_if.pulso[2] === 1'b1) begin
            cnt++;
            if (pos < 0) pos = t;
         end
      end
      checks++;
      if (cnt !== exp_cnt || (exp_cnt == 1 && pos !== 6)) begin
         failures++;
         $display("FAIL %s: pulses=%0d at tick %0d expected %0d at tick 6", nombre, cnt, pos, exp_cnt);
      end
      checks++;
      if (bus_if.nivel[2] !== val) begin
         failures++;
         $display("FAIL %s_nivel: nivel2=%b expected %b", nombre, bus_if.nivel[2], val);
      end
   endtask
   task automatic test_modos();
      bus_if.modo[5:4] = 2'b11;
      run_canal2(1'b1, 1, "ambos_rise");
      run_canal2(1'b0, 1, "ambos_fall");
      bus_if.modo[5:4] = 2'b10;
      run_canal2(1'b1, 0, "bajada_rise");
      run_canal2(1'b0, 1, "bajada_fall");
      bus_if.modo[3:2] = 2'b00;
      bus_if.inp[1] = 1'b1;
      repeat (6) tick();
      checks++;
      if (bus_if.nivel[1] !== 1'b1 || bus_if.pulso[1] !== 1'b0) begin
         failures++;
         $display("FAIL modo_off: nivel1=%b pulso1=%b expected 1/0", bus_if.nivel[1], bus_if.pulso[1]);
      end
   endtask
   task automatic test_simultaneo();
      bus_if.modo = 8'h55;
      settle_low();
      bus_if.inp = 4'b1111;
      repeat (6) tick();
      checks++;
      if (bus_if.pulso !== 4'b1111) begin
         failures++;
         $display("FAIL simultaneo: pulso=%b expected 1111", bus_if.pulso);
      end
      tick();
      checks++;
      if (bus_if.pulso !== 4'b0000 || bus_if.nivel !== 4'b1111) begin
         failures++;
         $display("FAIL simultaneo_after: pulso=%b nivel=%b expected 0000/1111", bus_if.pulso, bus_if.nivel);
      end
   endtask
   task automatic test_reset_mid();
      settle_low();
      bus_if.inp[3] = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      checks++;
      if (bus_if.nivel !== 4'b0000 || bus_if.pulso !== 4'b0000) begin
         failures++;
         $display("FAIL reset_async: nivel=%b pulso=%b expected 0000/0000", bus_if.nivel, bus_if.pulso);
      end
      repeat (3) tick();
      checks++;
      if (bus_if.nivel[3] !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold: nivel3=%b expected 0", bus_if.nivel[3]);
      end
      rst = 1'b0;
      repeat (5) tick();
      checks++;
      if (bus_if.nivel[3] !== 1'b0 || bus_if.pulso[3] !== 1'b0) begin
         failures++;
         $display("FAIL reset_requal_early: nivel3=%b pulso3=%b expected 0/0", bus_if.nivel[3], bus_if.pulso[3]);
      end
      tick();
      checks++;
      if (bus_if.nivel[3] !== 1'b1 || bus_if.pulso[3] !== 1'b1) begin
         failures++;
         $display("FAIL reset_requal: nivel3=%b pulso3=%b expected 1/1", bus_if.nivel[3], bus_if.pulso[3]);
      end
   endtask
`ifdef SINC_STICKY_EN
   task automatic test_sticky();
      settle_low();
      bus_if.limpiar = 4'b0001;
      bus_if.inp[0] = 1'b1;
      repeat (5) tick();
      checks++;
      if (bus_if.evento[0] !== 1'b0) begin
         failures++;
         $display("FAIL sticky_idle: evento0=%b expected 0", bus_if.evento[0]);
      end
      tick();
      checks++;
      if (bus_if.pulso[0] !== 1'b1 || bus_if.evento[0] !== 1'b1) begin
         failures++;
         $display("FAIL sticky_set: pulso0=%b evento0=%b expected 1/1", bus_if.pulso[0], bus_if.evento[0]);
      end
      tick();
      checks++;
      if (bus_if.evento[0] !== 1'b0) begin
         failures++;
         $display("FAIL sticky_clear: evento0=%b expected 0", bus_if.evento[0]);
      end
      bus_if.limpiar = 4'b0000;
   endtask
`endif
   initial begin
      test_reset();
      test_subida();
      test_glitch();
      test_modos();
      test_simultaneo();
      test_reset_mid();
`ifdef SINC_STICKY_EN
      test_sticky();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
